// File: rtl/mini_alu_pkg.sv
// mini_alu_pkg
//   Shared definitions for the mini_alu_core execution core: instruction
//   width and field positions, opcode encodings, the operand addresses that
//   alias the RL/RH product registers, and the multiplier sequencing states
//   used when MINI_ALU_MUL_PIPE_EN is defined.
package mini_alu_pkg;

  localparam int INSTR_W  = 28;

  // Instruction layout: {op, dst, src1, src0}
  localparam int OP_MSB   = 27;
  localparam int OP_LSB   = 24;
  localparam int DST_MSB  = 23;
  localparam int DST_LSB  = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC0_MSB = 7;
  localparam int SRC0_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SMUL = 4'd3;
  localparam logic [3:0] OP_STO  = 4'd4;
  localparam logic [3:0] OP_BLE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_LED  = 4'd7;
  localparam logic [3:0] OP_VGA  = 4'd8;
  localparam logic [3:0] OP_CALL = 4'd9;
  localparam logic [3:0] OP_RET  = 4'd10;

  // Operand addresses that read the product registers instead of RAM
  localparam logic [7:0] RL_ADDR = 8'hFE;
  localparam logic [7:0] RH_ADDR = 8'hFF;

  // Bubble inserted into the execute register on a taken branch
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 24'd0};

  typedef enum logic {
    MUL_IDLE,
    MUL_WAIT
  } mulState_t;

endpackage

// File: rtl/mini_alu_ret_stack.sv
// mini_alu_ret_stack
//   Hardware return-address stack for CALL/RET. Push and pop are ignored
//   when the stack is full or empty respectively; the caller decides what a
//   dropped push or an empty pop means.
// Ports:
//   Clock, Reset        clock, asynchronous active-high reset
//   iPush / iPushData   push a return address
//   iPop                discard the top entry
//   oTop                current top-of-stack (valid when !oEmpty)
//   oFull / oEmpty      occupancy flags
module mini_alu_ret_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int IP_W        = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            iPush,
  input  logic            iPop,
  input  logic [IP_W-1:0] iPushData,
  output logic [IP_W-1:0] oTop,
  output logic            oFull,
  output logic            oEmpty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] r_count;
  logic [IP_W-1:0]  r_mem [STACK_DEPTH];
  logic [PTR_W-1:0] w_topIdx;

  // The count is one wider than the pointer so "full" is representable;
  // its low bits minus one always index the newest entry.
  assign w_topIdx = r_count[PTR_W-1:0] - PTR_W'(1);
  assign oTop     = r_mem[w_topIdx];
  assign oFull    = (r_count == CNT_W'(STACK_DEPTH));
  assign oEmpty   = (r_count == '0);

  // Entry storage and occupancy count
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (iPush && !oFull) begin
      r_mem[r_count[PTR_W-1:0]] <= iPushData;
      r_count                   <= r_count + CNT_W'(1);
    end else if (iPop && !oEmpty) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mini_alu_core.sv
// mini_alu_core
//   Two-stage (fetch / execute) 28-bit-instruction core. Owns the IP, the
//   execute register, ALU, RL/RH product registers, distance-1 operand
//   bypass, LED register and the return-address stack. ROM, data RAM and
//   video memory are external.
// Configuration macro:
//   MINI_ALU_MUL_PIPE_EN  registered multiplier; SMUL stalls fetch for one
//                         extra cycle and writes RL/RH in its second cycle.
//                         Undefined: single-cycle combinational SMUL.
// Ports:
//   Clock, Reset                 clock, asynchronous active-high reset
//   oIP / iInstruction           ROM address / combinational instruction
//   oRdAddr0/1, iRdData0/1       synchronous-read RAM ports (src0 / src1)
//   oWrEn, oWrAddr, oWrData      RAM write-back (ADD/SUB/STO)
//   oVidWrEn, oVidX/Y, oVidColor video memory pixel write
//   oLed                         LED register
//   oStackFault                  sticky call-stack overflow/underflow
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [IP_W-1:0]    oIP,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [7:0]         oRdAddr0,
  output logic [7:0]         oRdAddr1,
  input  logic [DATA_W-1:0]  iRdData0,
  input  logic [DATA_W-1:0]  iRdData1,
  output logic               oWrEn,
  output logic [7:0]         oWrAddr,
  output logic [DATA_W-1:0]  oWrData,
  output logic               oVidWrEn,
  output logic [DATA_W-1:0]  oVidX,
  output logic [DATA_W-1:0]  oVidY,
  output logic [2:0]         oVidColor,
  output logic [7:0]         oLed,
  output logic               oStackFault
);

  logic [IP_W-1:0]     r_ip;
  logic [INSTR_W-1:0]  r_instr;
  logic [DATA_W-1:0]   r_rl;
  logic [DATA_W-1:0]   r_rh;
  logic [7:0]          r_led;
  logic                r_bypValid;
  logic [7:0]          r_bypAddr;
  logic [DATA_W-1:0]   r_bypData;
  logic                r_stackFault;

  logic [3:0]          w_op;
  logic [7:0]          w_dst;
  logic [7:0]          w_src1;
  logic [7:0]          w_src0;
  logic [15:0]         w_imm;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [2*DATA_W-1:0] w_aExt;
  logic [2*DATA_W-1:0] w_bExt;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_isSmul;
  logic                w_wrEn;
  logic [DATA_W-1:0]   w_wrData;
  logic                w_vidWrEn;
  logic                w_ledWe;
  logic                w_branch;
  logic [IP_W-1:0]     w_target;
  logic                w_push;
  logic                w_pop;
  logic                w_faultSet;
  logic                w_stall;
  logic                w_rlrhWe;
  logic [2*DATA_W-1:0] w_rlrhData;
  logic [IP_W-1:0]     w_stackTop;
  logic                w_stackFull;
  logic                w_stackEmpty;

  assign w_op     = r_instr[OP_MSB:OP_LSB];
  assign w_dst    = r_instr[DST_MSB:DST_LSB];
  assign w_src1   = r_instr[SRC1_MSB:SRC1_LSB];
  assign w_src0   = r_instr[SRC0_MSB:SRC0_LSB];
  assign w_imm    = {w_src1, w_src0};
  assign w_isSmul = (w_op == OP_SMUL);

  // RAM read addresses come straight from the instruction being fetched so
  // the data lands exactly when that instruction reaches execute.
  assign oRdAddr0 = iInstruction[SRC0_MSB:SRC0_LSB];
  assign oRdAddr1 = iInstruction[SRC1_MSB:SRC1_LSB];

  // Operand selection: FE/FF alias RL/RH; a write made by the immediately
  // preceding instruction has not reached the RAM read yet, so forward it.
  always_comb begin
    w_a = iRdData0;
    if (w_src0 == RL_ADDR) begin
      w_a = r_rl;
    end else if (w_src0 == RH_ADDR) begin
      w_a = r_rh;
    end else if (r_bypValid && (r_bypAddr == w_src0)) begin
      w_a = r_bypData;
    end

    w_b = iRdData1;
    if (w_src1 == RL_ADDR) begin
      w_b = r_rl;
    end else if (w_src1 == RH_ADDR) begin
      w_b = r_rh;
    end else if (r_bypValid && (r_bypAddr == w_src1)) begin
      w_b = r_bypData;
    end
  end

  // Sign-extending to the full product width lets an unsigned multiply
  // produce the correct low 2*DATA_W bits of the signed product.
  assign w_aExt = {{DATA_W{w_a[DATA_W-1]}}, w_a};
  assign w_bExt = {{DATA_W{w_b[DATA_W-1]}}, w_b};
  assign w_prod = w_aExt * w_bExt;

  // Execute-stage decode: strobes, write-back data, branch and stack control
  always_comb begin
    w_wrEn     = 1'b0;
    w_wrData   = w_b + w_a;
    w_vidWrEn  = 1'b0;
    w_ledWe    = 1'b0;
    w_branch   = 1'b0;
    w_target   = IP_W'(w_dst);
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_faultSet = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_wrEn   = 1'b1;
        w_wrData = w_b + w_a;
      end
      OP_SUB: begin
        w_wrEn   = 1'b1;
        w_wrData = w_b - w_a;
      end
      OP_STO: begin
        w_wrEn   = 1'b1;
        w_wrData = DATA_W'(w_imm);
      end
      OP_BLE: begin
        w_branch = ($signed(w_b) <= $signed(w_a));
      end
      OP_JMP: begin
        w_branch = 1'b1;
      end
      OP_LED: begin
        w_ledWe = 1'b1;
      end
      OP_VGA: begin
        w_vidWrEn = 1'b1;
      end
      OP_CALL: begin
        // An overflowing CALL still branches; only the return address is lost
        w_branch = 1'b1;
        if (w_stackFull) begin
          w_faultSet = 1'b1;
        end else begin
          w_push = 1'b1;
        end
      end
      OP_RET: begin
        // An underflowing RET falls through to the next instruction
        if (w_stackEmpty) begin
          w_faultSet = 1'b1;
        end else begin
          w_pop    = 1'b1;
          w_branch = 1'b1;
          w_target = w_stackTop;
        end
      end
      default: begin
      end
    endcase
  end

`ifdef MINI_ALU_MUL_PIPE_EN
  mulState_t           r_mulState;
  mulState_t           w_mulNext;
  logic [2*DATA_W-1:0] r_prod;

  // Multiplier sequencing state and the registered product
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mulState <= MUL_IDLE;
      r_prod     <= '0;
    end else begin
      r_mulState <= w_mulNext;
      if ((r_mulState == MUL_IDLE) && w_isSmul) begin
        r_prod <= w_prod;
      end
    end
  end

  // First SMUL cycle captures the product and freezes fetch; the second
  // cycle retires it into RL/RH and lets the pipeline advance.
  always_comb begin
    w_mulNext = r_mulState;
    w_stall   = 1'b0;
    w_rlrhWe  = 1'b0;
    case (r_mulState)
      MUL_IDLE: begin
        if (w_isSmul) begin
          w_stall   = 1'b1;
          w_mulNext = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        w_rlrhWe  = 1'b1;
        w_mulNext = MUL_IDLE;
      end
      default: begin
        w_mulNext = MUL_IDLE;
      end
    endcase
  end

  assign w_rlrhData = r_prod;
`else
  assign w_stall    = 1'b0;
  assign w_rlrhWe   = w_isSmul;
  assign w_rlrhData = w_prod;
`endif

  mini_alu_ret_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .IP_W        (IP_W)
  ) u_retStack (
    .Clock     (Clock),
    .Reset     (Reset),
    .iPush     (w_push),
    .iPop      (w_pop),
    .iPushData (r_ip),
    .oTop      (w_stackTop),
    .oFull     (w_stackFull),
    .oEmpty    (w_stackEmpty)
  );

  // Fetch/execute advance, bypass capture and architectural registers.
  // r_ip always points one past the executing instruction, which is exactly
  // the return address a CALL must push.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_ip         <= '0;
      r_instr      <= NOP_INSTR;
      r_rl         <= '0;
      r_rh         <= '0;
      r_led        <= '0;
      r_bypValid   <= 1'b0;
      r_bypAddr    <= '0;
      r_bypData    <= '0;
      r_stackFault <= 1'b0;
    end else begin
      if (!w_stall) begin
        if (w_branch) begin
          r_ip    <= w_target;
          r_instr <= NOP_INSTR;
        end else begin
          r_ip    <= r_ip + IP_W'(1);
          r_instr <= iInstruction;
        end
      end
      r_bypValid <= w_wrEn;
      r_bypAddr  <= w_dst;
      r_bypData  <= w_wrData;
      if (w_ledWe) begin
        r_led <= w_b[7:0];
      end
      if (w_faultSet) begin
        r_stackFault <= 1'b1;
      end
      if (w_rlrhWe) begin
        {r_rh, r_rl} <= w_rlrhData;
      end
    end
  end

  assign oIP         = r_ip;
  assign oWrEn       = w_wrEn;
  assign oWrAddr     = w_dst;
  assign oWrData     = w_wrData;
  assign oVidWrEn    = w_vidWrEn;
  assign oVidX       = w_a;
  assign oVidY       = w_b;
  assign oVidColor   = w_dst[2:0];
  assign oLed        = r_led;
  assign oStackFault = r_stackFault;

endmodule

// File: tb/tb_mini_alu_core.sv
// tb_mini_alu_core
//   Bench for mini_alu_core (DATA_W=16, IP_W=16, STACK_DEPTH=4) with a
//   combinational ROM and a synchronous-read data RAM. A per-cycle vector
//   table covers the ALU/bypass/branch/LED/VGA program; hand-written
//   sequences cover SMUL, the call stack and mid-instruction reset.
module tb_mini_alu_core;

  localparam logic [3:0] T_ADD  = 4'd1;
  localparam logic [3:0] T_SUB  = 4'd2;
  localparam logic [3:0] T_SMUL = 4'd3;
  localparam logic [3:0] T_STO  = 4'd4;
  localparam logic [3:0] T_BLE  = 4'd5;
  localparam logic [3:0] T_JMP  = 4'd6;
  localparam logic [3:0] T_LED  = 4'd7;
  localparam logic [3:0] T_VGA  = 4'd8;
  localparam logic [3:0] T_CALL = 4'd9;
  localparam logic [3:0] T_RET  = 4'd10;

  typedef struct packed {
    logic [15:0] ip;
    logic        wrEn;
    logic [7:0]  wrAddr;
    logic [15:0] wrData;
    logic        vidEn;
    logic [15:0] vidX;
    logic [15:0] vidY;
    logic [2:0]  color;
    logic [7:0]  led;
  } vec_t;

  logic        Clock;
  logic        Reset;
  logic [15:0] oIP;
  logic [27:0] iInstruction;
  logic [7:0]  oRdAddr0;
  logic [7:0]  oRdAddr1;
  logic [15:0] iRdData0;
  logic [15:0] iRdData1;
  logic        oWrEn;
  logic [7:0]  oWrAddr;
  logic [15:0] oWrData;
  logic        oVidWrEn;
  logic [15:0] oVidX;
  logic [15:0] oVidY;
  logic [2:0]  oVidColor;
  logic [7:0]  oLed;
  logic        oStackFault;

  logic [27:0] rom [0:255];
  logic [15:0] ram [0:255];
  logic        ramClear;
  int          testsRun;
  int          testsFailed;
  vec_t        vecs [21];
  logic [15:0] stackIps [22];

  mini_alu_core #(
    .DATA_W      (16),
    .IP_W        (16),
    .STACK_DEPTH (4)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oIP          (oIP),
    .iInstruction (iInstruction),
    .oRdAddr0     (oRdAddr0),
    .oRdAddr1     (oRdAddr1),
    .iRdData0     (iRdData0),
    .iRdData1     (iRdData1),
    .oWrEn        (oWrEn),
    .oWrAddr      (oWrAddr),
    .oWrData      (oWrData),
    .oVidWrEn     (oVidWrEn),
    .oVidX        (oVidX),
    .oVidY        (oVidY),
    .oVidColor    (oVidColor),
    .oLed         (oLed),
    .oStackFault  (oStackFault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign iInstruction = rom[oIP[7:0]];

  // External data RAM: synchronous read returning pre-write contents
  always @(posedge Clock) begin
    if (ramClear) begin
      for (int i = 0; i < 256; i++) begin
        ram[i] <= 16'h0000;
      end
    end else if (oWrEn) begin
      ram[oWrAddr] <= oWrData;
    end
    iRdData0 <= ram[oRdAddr0];
    iRdData1 <= ram[oRdAddr1];
  end

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, tests run %0d", testsRun);
    $fatal(1, "[TB] time limit");
  end

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] dst,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, dst, s1, s0};
  endfunction

  function automatic vec_t mkVec(input logic [15:0] ip, input logic wrEn,
                                 input logic [7:0] wrAddr, input logic [15:0] wrData,
                                 input logic vidEn, input logic [15:0] vidX,
                                 input logic [15:0] vidY, input logic [2:0] color,
                                 input logic [7:0] led);
    vec_t v;
    v.ip = ip; v.wrEn = wrEn; v.wrAddr = wrAddr; v.wrData = wrData;
    v.vidEn = vidEn; v.vidX = vidX; v.vidY = vidY; v.color = color; v.led = led;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(negedge Clock);
    #1;
  endtask

  // Load a program into ROM, clear RAM and reset; returns in cycle 0
  task automatic applyStimulus(input int prog);
    Reset    = 1'b1;
    ramClear = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 28'h0;
    case (prog)
      0: begin
        rom[0]  = ins(T_STO, 8'd1, 8'h00, 8'h05);
        rom[1]  = ins(T_STO, 8'd2, 8'h00, 8'h03);
        rom[2]  = ins(T_ADD, 8'd3, 8'd2, 8'd1);
        rom[3]  = ins(T_SUB, 8'd4, 8'd3, 8'd1);
        rom[4]  = ins(T_BLE, 8'd20, 8'd2, 8'd1);
        rom[5]  = ins(T_STO, 8'd9, 8'h00, 8'h77);
        rom[20] = ins(T_STO, 8'd8, 8'hFF, 8'hFF);
        rom[21] = ins(T_ADD, 8'd9, 8'd8, 8'd1);
        rom[22] = ins(T_SUB, 8'd10, 8'd0, 8'd1);
        rom[23] = ins(T_BLE, 8'd40, 8'd1, 8'd2);
        rom[24] = ins(T_STO, 8'd5, 8'h00, 8'hA5);
        rom[25] = ins(T_LED, 8'd0, 8'd5, 8'd0);
        rom[26] = ins(T_STO, 8'd6, 8'h00, 8'd10);
        rom[27] = ins(T_STO, 8'd7, 8'h00, 8'd7);
        rom[28] = ins(T_VGA, 8'd5, 8'd7, 8'd6);
        rom[29] = ins(T_BLE, 8'd40, 8'd10, 8'd0);
        rom[40] = ins(T_JMP, 8'd40, 8'd0, 8'd0);
      end
      1: begin
        rom[0] = ins(T_STO, 8'd1, 8'hFF, 8'hFD);
        rom[1] = ins(T_STO, 8'd2, 8'h03, 8'hE8);
        rom[2] = ins(T_SMUL, 8'd0, 8'd2, 8'd1);
        rom[3] = ins(T_ADD, 8'd3, 8'hFE, 8'd0);
        rom[4] = ins(T_ADD, 8'd4, 8'hFF, 8'd0);
        rom[5] = ins(T_JMP, 8'd5, 8'd0, 8'd0);
      end
      default: begin
        rom[0]  = ins(T_CALL, 8'd10, 8'd0, 8'd0);
        rom[10] = ins(T_CALL, 8'd20, 8'd0, 8'd0);
        rom[20] = ins(T_CALL, 8'd30, 8'd0, 8'd0);
        rom[30] = ins(T_CALL, 8'd40, 8'd0, 8'd0);
        rom[40] = ins(T_CALL, 8'd50, 8'd0, 8'd0);
        rom[50] = ins(T_RET, 8'd0, 8'd0, 8'd0);
        rom[31] = ins(T_RET, 8'd0, 8'd0, 8'd0);
        rom[21] = ins(T_RET, 8'd0, 8'd0, 8'd0);
        rom[11] = ins(T_RET, 8'd0, 8'd0, 8'd0);
        rom[1]  = ins(T_RET, 8'd0, 8'd0, 8'd0);
        rom[2]  = ins(T_STO, 8'd1, 8'h00, 8'h55);
        rom[3]  = ins(T_ADD, 8'd2, 8'd1, 8'd0);
        rom[4]  = ins(T_JMP, 8'd4, 8'd0, 8'd0);
      end
    endcase
    repeat (3) @(negedge Clock);
    ramClear = 1'b0;
    Reset    = 1'b0;
    #1;
  endtask

  initial begin
    int waited;
    testsRun    = 0;
    testsFailed = 0;
    Reset       = 1'b1;
    ramClear    = 1'b1;

    // Per-cycle expectations for program 0 (cycle 0 = first cycle after reset)
    vecs[0]  = mkVec(16'd0,  0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[1]  = mkVec(16'd1,  1, 8'd1,  16'h0005, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[2]  = mkVec(16'd2,  1, 8'd2,  16'h0003, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[3]  = mkVec(16'd3,  1, 8'd3,  16'h0008, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[4]  = mkVec(16'd4,  1, 8'd4,  16'h0003, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[5]  = mkVec(16'd5,  0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[6]  = mkVec(16'd20, 0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[7]  = mkVec(16'd21, 1, 8'd8,  16'hFFFF, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[8]  = mkVec(16'd22, 1, 8'd9,  16'h0004, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[9]  = mkVec(16'd23, 1, 8'd10, 16'hFFFB, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[10] = mkVec(16'd24, 0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[11] = mkVec(16'd25, 1, 8'd5,  16'h00A5, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[12] = mkVec(16'd26, 0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'h00);
    vecs[13] = mkVec(16'd27, 1, 8'd6,  16'h000A, 0, 16'd0,  16'd0, 3'd0, 8'hA5);
    vecs[14] = mkVec(16'd28, 1, 8'd7,  16'h0007, 0, 16'd0,  16'd0, 3'd0, 8'hA5);
    vecs[15] = mkVec(16'd29, 0, 8'd0,  16'h0000, 1, 16'd10, 16'd7, 3'd5, 8'hA5);
    vecs[16] = mkVec(16'd30, 0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'hA5);
    vecs[17] = mkVec(16'd40, 0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'hA5);
    vecs[18] = mkVec(16'd41, 0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'hA5);
    vecs[19] = mkVec(16'd40, 0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'hA5);
    vecs[20] = mkVec(16'd41, 0, 8'd0,  16'h0000, 0, 16'd0,  16'd0, 3'd0, 8'hA5);

    stackIps = '{16'd0, 16'd1, 16'd10, 16'd11, 16'd20, 16'd21, 16'd30, 16'd31,
                 16'd40, 16'd41, 16'd50, 16'd51, 16'd31, 16'd32, 16'd21, 16'd22,
                 16'd11, 16'd12, 16'd1, 16'd2, 16'd3, 16'd4};

    // ALU, bypass, branch, LED and VGA program
    applyStimulus(0);
    for (int c = 0; c < 21; c++) begin
      if (c > 0) stepCycle();
      checkOutput($sformatf("progA ip c%0d", c), 32'(oIP), 32'(vecs[c].ip));
      checkOutput($sformatf("progA wrEn c%0d", c), 32'(oWrEn), 32'(vecs[c].wrEn));
      if (vecs[c].wrEn) begin
        checkOutput($sformatf("progA wrAddr c%0d", c), 32'(oWrAddr), 32'(vecs[c].wrAddr));
        checkOutput($sformatf("progA wrData c%0d", c), 32'(oWrData), 32'(vecs[c].wrData));
      end
      checkOutput($sformatf("progA vidEn c%0d", c), 32'(oVidWrEn), 32'(vecs[c].vidEn));
      if (vecs[c].vidEn) begin
        checkOutput($sformatf("progA vidX c%0d", c), 32'(oVidX), 32'(vecs[c].vidX));
        checkOutput($sformatf("progA vidY c%0d", c), 32'(oVidY), 32'(vecs[c].vidY));
        checkOutput($sformatf("progA color c%0d", c), 32'(oVidColor), 32'(vecs[c].color));
      end
      checkOutput($sformatf("progA led c%0d", c), 32'(oLed), 32'(vecs[c].led));
      checkOutput($sformatf("progA fault c%0d", c), 32'(oStackFault), 32'd0);
    end

    // SMUL -3 * 1000, then read RL and RH back through ADD
    applyStimulus(1);
    repeat (3) stepCycle();
    checkOutput("smul ip at execute", 32'(oIP), 32'd3);
    checkOutput("smul no write", 32'(oWrEn), 32'd0);
    stepCycle();
`ifdef MINI_ALU_MUL_PIPE_EN
    checkOutput("smul ip hold", 32'(oIP), 32'd3);
    checkOutput("smul stage2 no write", 32'(oWrEn), 32'd0);
`else
    checkOutput("smul ip advance", 32'(oIP), 32'd4);
`endif
    waited = 0;
    while (!(oWrEn && (oWrAddr == 8'd3)) && (waited < 8)) begin
      stepCycle();
      waited++;
    end
    if (waited >= 8) begin
      checkOutput("smul RL write timeout", 32'(waited), 32'd0);
    end else begin
      checkOutput("smul RL via FE", 32'(oWrData), 32'h0000F448);
      stepCycle();
      checkOutput("smul RH addr", 32'(oWrAddr), 32'd4);
      checkOutput("smul RH via FF", 32'(oWrData), 32'h0000FFFF);
    end

    // Nested CALL x5 into a 4-deep stack, then 5 RETs
    applyStimulus(2);
    for (int c = 0; c < 22; c++) begin
      if (c > 0) stepCycle();
      checkOutput($sformatf("stack ip c%0d", c), 32'(oIP), 32'(stackIps[c]));
      checkOutput($sformatf("stack wrEn c%0d", c), 32'(oWrEn), (c >= 20) ? 32'd1 : 32'd0);
      checkOutput($sformatf("stack fault c%0d", c), 32'(oStackFault), (c >= 10) ? 32'd1 : 32'd0);
    end
    checkOutput("stack fallthrough addr", 32'(oWrAddr), 32'd2);
    checkOutput("stack fallthrough data", 32'(oWrData), 32'h00000055);

    // Reset asserted mid-cycle while ADD is executing
    Reset = 1'b1;
    #1;
    checkOutput("reset wrEn", 32'(oWrEn), 32'd0);
    checkOutput("reset ip", 32'(oIP), 32'd0);
    checkOutput("reset fault", 32'(oStackFault), 32'd0);
    checkOutput("reset led", 32'(oLed), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
